hex7seg_scan_decoder: RTL and testbench

- Receiver end of the 7-segment hex display path: takes a time-multiplexed, active-low segment stream (one digit per beat, one-hot digit select) and reconstructs the 24-bit word shown on six hex digits.
- Sits on the display bus for loopback checking and self-test of the hex display encoder.
- Publishes a word only after it has been seen unchanged for STABLE_FRAMES complete scans.

---
 rtl/hex7seg_scan_decoder.sv | 169 ++++++++++++++++
 tb/tb_hex7seg_scan_decoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex7seg_scan_decoder.sv
// Receiver for a time-multiplexed active-low 7-segment hex stream: reassembles
// six digits into a 24-bit word and publishes it once it is stable across frames.
module hex7seg_scan_decoder #(
    parameter int unsigned STABLE_FRAMES = 2,
    parameter int unsigned DIGIT_TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        seg_valid_i,
    input  logic [6:0]  seg_i,
    input  logic [5:0]  dig_sel_i,
    output logic [23:0] data_o,
    output logic        data_valid_o,
    output logic        frame_err_o,
    output logic        nibble_err_o
);
    localparam int unsigned TW = $clog2(DIGIT_TIMEOUT + 1);
    localparam int unsigned SW = $clog2(STABLE_FRAMES + 1);

    typedef enum logic {IDLE, COLLECT} state_e;

    state_e        state_q, state_d;
    logic [5:0]    mask_q, mask_d;
    logic [23:0]   asm_q, asm_d;
    logic [23:0]   cand_q, cand_d;
    logic          cand_ok_q, cand_ok_d;
    logic [23:0]   data_q, data_d;
    logic          pub_q, pub_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [SW-1:0] stab_q, stab_d;
    logic          dv_q, dv_d, fe_q, fe_d, ne_q, ne_d;

    logic [3:0]    nib;
    logic          nib_ok;
    logic [2:0]    idx;
    logic [23:0]   asm_ins;

    // Active-low segment pattern to hex nibble
    always_comb begin
        nib    = 4'h0;
        nib_ok = 1'b1;
        case (seg_i)
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h18: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: nib_ok = 1'b0;
        endcase
    end

    always_comb begin
        idx = 3'd0;
        for (int k = 0; k < 6; k++) begin
            if (dig_sel_i[k]) idx = 3'(k);
        end
        asm_ins = (asm_q & ~(24'hF << {idx, 2'b00})) | (24'(nib) << {idx, 2'b00});
    end

    // Next-state: beat classification, timeout, frame completion and publish
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        asm_d     = asm_q;
        cand_d    = cand_q;
        cand_ok_d = cand_ok_q;
        data_d    = data_q;
        pub_d     = pub_q;
        tmo_d     = tmo_q;
        stab_d    = stab_q;
        dv_d      = 1'b0;
        fe_d      = 1'b0;
        ne_d      = 1'b0;
        if (seg_valid_i) begin
            if (!$onehot(dig_sel_i) || !nib_ok) begin
                fe_d    = !$onehot(dig_sel_i);
                ne_d    = $onehot(dig_sel_i);
                mask_d  = 6'h00;
                tmo_d   = '0;
                stab_d  = '0;
                state_d = IDLE;
            end else if (|(mask_q & dig_sel_i)) begin
                fe_d    = 1'b1;
                stab_d  = '0;
                mask_d  = dig_sel_i;
                asm_d   = asm_ins;
                tmo_d   = '0;
                state_d = COLLECT;
            end else begin
                mask_d  = mask_q | dig_sel_i;
                asm_d   = asm_ins;
                tmo_d   = '0;
                state_d = COLLECT;
                if (&mask_d) begin
                    mask_d  = 6'h00;
                    state_d = IDLE;
                    if (cand_ok_q && asm_d == cand_q) begin
                        if (stab_q != SW'(STABLE_FRAMES)) stab_d = stab_q + SW'(1);
                    end else begin
                        cand_d    = asm_d;
                        cand_ok_d = 1'b1;
                        stab_d    = SW'(1);
                    end
                    if (stab_d == SW'(STABLE_FRAMES) && (!pub_q || cand_d != data_q)) begin
                        data_d = cand_d;
                        dv_d   = 1'b1;
                        pub_d  = 1'b1;
                    end
                end
            end
        end else if (state_q == COLLECT) begin
            if (tmo_q == TW'(DIGIT_TIMEOUT - 1)) begin
                fe_d    = 1'b1;
                mask_d  = 6'h00;
                tmo_d   = '0;
                stab_d  = '0;
                state_d = IDLE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            mask_q    <= 6'h00;
            asm_q     <= 24'h0;
            cand_q    <= 24'h0;
            cand_ok_q <= 1'b0;
            data_q    <= 24'h0;
            pub_q     <= 1'b0;
            tmo_q     <= '0;
            stab_q    <= '0;
            dv_q      <= 1'b0;
            fe_q      <= 1'b0;
            ne_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            asm_q     <= asm_d;
            cand_q    <= cand_d;
            cand_ok_q <= cand_ok_d;
            data_q    <= data_d;
            pub_q     <= pub_d;
            tmo_q     <= tmo_d;
            stab_q    <= stab_d;
            dv_q      <= dv_d;
            fe_q      <= fe_d;
            ne_q      <= ne_d;
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = dv_q;
    assign frame_err_o  = fe_q;
    assign nibble_err_o = ne_q;
endmodule

// File: tb/tb_hex7seg_scan_decoder.sv
// Directed plus randomized bench for hex7seg_scan_decoder against a frame-level model.
module tb_hex7seg_scan_decoder;
    localparam int SF = 2;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        seg_valid = 1'b0;
    logic [6:0]  seg = 7'h7F;
    logic [5:0]  dig_sel = 6'h00;
    logic [23:0] data;
    logic        data_valid, frame_err, nibble_err;

    int errors = 0;
    int checks = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state, kept per digit and per frame
    bit          have [6];
    int          slot [6];
    int          idle;
    int          stable;
    logic [23:0] cand;
    bit          cand_ok, pub;
    logic [23:0] m_data;
    bit          m_dv, m_fe, m_ne;

    hex7seg_scan_decoder #(.STABLE_FRAMES(SF), .DIGIT_TIMEOUT(TO)) dut (
        .clk_i(clk), .reset_i(reset), .seg_valid_i(seg_valid), .seg_i(seg),
        .dig_sel_i(dig_sel), .data_o(data), .data_valid_o(data_valid),
        .frame_err_o(frame_err), .nibble_err_o(nibble_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit any_have();
        bit r = 0;
        for (int i = 0; i < 6; i++) r |= have[i];
        return r;
    endfunction

    task automatic drop_frame();
        for (int i = 0; i < 6; i++) have[i] = 0;
        idle   = 0;
        stable = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin have[i] = 0; slot[i] = 0; end
        idle = 0; stable = 0; cand = 0; cand_ok = 0; pub = 0;
        m_data = 0; m_dv = 0; m_fe = 0; m_ne = 0;
    endtask

    task automatic model_step(input bit v, input logic [6:0] s, input logic [5:0] d);
        int k, n, cnt;
        bit all;
        logic [23:0] w;
        m_dv = 0; m_fe = 0; m_ne = 0;
        if (v) begin
            k = -1; n = -1; cnt = 0;
            for (int i = 0; i < 6; i++) if (d[i]) begin cnt++; k = i; end
            for (int i = 0; i < 16; i++) if (seg_tab[i] == s) n = i;
            if (cnt != 1) begin
                m_fe = 1; drop_frame();
            end else if (n < 0) begin
                m_ne = 1; drop_frame();
            end else if (have[k]) begin
                m_fe = 1; drop_frame();
                have[k] = 1; slot[k] = n;
            end else begin
                have[k] = 1; slot[k] = n; idle = 0;
                all = 1;
                for (int i = 0; i < 6; i++) all &= have[i];
                if (all) begin
                    w = 0;
                    for (int i = 0; i < 6; i++) w += 24'(slot[i]) * (24'd1 << (4 * i));
                    for (int i = 0; i < 6; i++) have[i] = 0;
                    if (cand_ok && w == cand) stable = (stable + 1 > SF) ? SF : stable + 1;
                    else begin cand = w; cand_ok = 1; stable = 1; end
                    if (stable == SF && (!pub || cand != m_data)) begin
                        m_data = cand; m_dv = 1; pub = 1;
                    end
                end
            end
        end else if (any_have()) begin
            idle++;
            if (idle == TO) begin m_fe = 1; drop_frame(); end
        end
    endtask

    task automatic compare_all();
        check("data", data, m_data);
        check("data_valid", 24'(data_valid), 24'(m_dv));
        check("frame_err", 24'(frame_err), 24'(m_fe));
        check("nibble_err", 24'(nibble_err), 24'(m_ne));
    endtask

    task automatic cycle(input bit v, input logic [6:0] s, input logic [5:0] d);
        seg_valid = v; seg = s; dig_sel = d;
        @(posedge clk);
        model_step(v, s, d);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1; seg_valid = 0;
        @(posedge clk);
        model_reset();
        #1;
        compare_all();
        check("reset_data_zero", data, 24'h0);
        reset = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 7'h7F, 6'h00);
    endtask

    task automatic beat(input int k, input logic [23:0] w);
        logic [3:0] nb;
        nb = w[4*k +: 4];
        cycle(1, seg_tab[nb], 6'(1) << k);
    endtask

    task automatic frame(input logic [23:0] w, input bit shuffle);
        int ord [6];
        int j, t;
        for (int i = 0; i < 6; i++) ord[i] = i;
        if (shuffle) begin
            for (int i = 5; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
        end
        for (int i = 0; i < 6; i++) beat(ord[i], w);
    endtask

    initial begin
        logic [23:0] pool [4];
        int r;
        pool = '{24'h3A5C7F, 24'h000000, 24'hABCDEF, 24'h3A5C7E};
        model_reset();
        do_reset();

        // Two identical frames publish, a third stays quiet
        frame(24'h3A5C7F, 0);
        frame(24'h3A5C7F, 0);
        check("pulse_after_frame2", 24'(data_valid), 24'h1);
        check("data_3A5C7F", data, 24'h3A5C7F);
        frame(24'h3A5C7F, 0);
        check("no_pulse_frame3", 24'(data_valid), 24'h0);

        // A changed word restarts the stability count
        frame(24'h123456, 0);
        frame(24'h123457, 0);
        check("no_pulse_after_change", 24'(data_valid), 24'h0);
        frame(24'h123457, 0);
        check("data_123457", data, 24'h123457);

        // Duplicate digit restarts the frame holding just that beat
        beat(0, 24'h654321); beat(1, 24'h654321); beat(2, 24'h654321); beat(1, 24'h654321);
        check("dup_frame_err", 24'(frame_err), 24'h1);
        beat(0, 24'h654321); beat(2, 24'h654321); beat(3, 24'h654321);
        beat(4, 24'h654321); beat(5, 24'h654321);
        frame(24'h654321, 0);
        check("data_654321", data, 24'h654321);

        // Blank pattern and multi-hot select
        beat(0, 24'h0); cycle(1, 7'h7F, 6'b000001);
        check("blank_nibble_err", 24'(nibble_err), 24'h1);
        cycle(1, 7'h7F, 6'b000011);
        check("multihot_frame_err", 24'(frame_err), 24'h1);
        check("multihot_no_nibble_err", 24'(nibble_err), 24'h0);

        // Timeout on expiry, then a beat on the expiry cycle keeps the frame
        beat(0, 24'h0); beat(1, 24'h0); beat(2, 24'h0);
        idle_cycles(TO);
        check("timeout_frame_err", 24'(frame_err), 24'h1);
        beat(0, 24'h0); beat(1, 24'h0); beat(2, 24'h0);
        idle_cycles(TO - 1);
        beat(3, 24'h0);
        check("beat_beats_timeout", 24'(frame_err), 24'h0);
        beat(4, 24'h0); beat(5, 24'h0);
        frame(24'h0, 1);
        check("data_000000", data, 24'h0);

        // Reset mid-frame
        beat(0, 24'hFFFFFF); beat(1, 24'hFFFFFF); beat(2, 24'hFFFFFF); beat(3, 24'hFFFFFF);
        do_reset();
        frame(24'hFFFFFF, 0);
        frame(24'hFFFFFF, 0);
        check("data_FFFFFF", data, 24'hFFFFFF);

        // Randomized mix of frames, gaps and protocol errors
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 19);
            if (r < 12) begin
                frame(pool[$urandom_range(0, 3)], 1);
            end else if (r < 14) begin
                cycle(1, 7'($urandom), 6'($urandom));
            end else if (r < 16) begin
                beat($urandom_range(0, 5), pool[$urandom_range(0, 3)]);
            end else if (r < 18) begin
                idle_cycles($urandom_range(TO - 2, TO + 1));
            end else begin
                idle_cycles($urandom_range(0, 3));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
